// File: rtl/cmd_filter_scan_if.sv
// Command/config bus for cmd_filter_scan: raw inputs, filtered outputs, scan enable and the
// per-channel hold-time write port.
interface cmd_filter_scan_if #(
   parameter int unsigned CH_NUM    = 8,
   parameter int unsigned CNT_WIDTH = 4
);
   localparam int unsigned ChW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   logic [CH_NUM-1:0]    in;
   logic [CH_NUM-1:0]    out;
   logic                 scan_en;
   logic                 cfg_wr;
   logic [ChW-1:0]       cfg_ch;
   logic [CNT_WIDTH-1:0] cfg_hold;
   logic                 cfg_ack;
   logic                 cfg_err;

   modport master (
      output in, scan_en, cfg_wr, cfg_ch, cfg_hold,
      input  out, cfg_ack, cfg_err
   );

   modport slave (
      input  in, scan_en, cfg_wr, cfg_ch, cfg_hold,
      output out, cfg_ack, cfg_err
   );
endinterface

// File: rtl/cmd_filter_scan.sv
// Round-robin command hold filter sharing one hold-counter update path across CH_NUM channels.
// Optional input synchronizer enabled by defining CMD_FILTER_SCAN_SYNC_EN.
module cmd_filter_scan #(
   parameter int unsigned CH_NUM       = 8,
   parameter int unsigned CNT_WIDTH    = 4,
   parameter int unsigned DEFAULT_HOLD = 2**CNT_WIDTH - 1
) (
   input logic              clk,
   input logic              aclr,
   cmd_filter_scan_if.slave bus
);
   localparam int unsigned PtrW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   typedef logic [CNT_WIDTH-1:0] cnt_t;

   localparam cnt_t              DefHold = cnt_t'(DEFAULT_HOLD);
   localparam logic [PtrW-1:0]   PtrMax  = PtrW'(CH_NUM - 1);
   localparam logic [CH_NUM-1:0] OutRst  = (DefHold != '0) ? '1 : '0;

   logic [PtrW-1:0]   ptr_q, ptr_d;
   cnt_t              hold_q [CH_NUM];
   cnt_t              hold_d [CH_NUM];
   cnt_t              cnt_q  [CH_NUM];
   cnt_t              cnt_d  [CH_NUM];
   logic [CH_NUM-1:0] out_q, out_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic [CH_NUM-1:0] in_s;
   logic              wr_ok;

`ifdef CMD_FILTER_SCAN_SYNC_EN
   logic [CH_NUM-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (aclr) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= bus.in;
         sync2_q <= sync1_q;
      end
   end

   assign in_s = sync2_q;
`else
   assign in_s = bus.in;
`endif

   assign wr_ok = bus.cfg_wr && (32'(bus.cfg_ch) < CH_NUM);

   always_comb begin
      cnt_t cur;
      hold_d = hold_q;
      cnt_d  = cnt_q;
      out_d  = out_q;
      ptr_d  = ptr_q;
      ack_d  = wr_ok;
      err_d  = bus.cfg_wr & ~wr_ok;
      cur    = '0;

      if (wr_ok) begin
         hold_d[bus.cfg_ch] = bus.cfg_hold;
         if (cnt_q[bus.cfg_ch] > bus.cfg_hold) begin
            cnt_d[bus.cfg_ch] = bus.cfg_hold;
         end
         if (bus.cfg_hold == '0) begin
            out_d[bus.cfg_ch] = 1'b0;
         end
      end

      // Service sees the post-write hold/count so a same-cycle write takes priority.
      if (bus.scan_en) begin
         cur = cnt_d[ptr_q];
         if (in_s[ptr_q]) begin
            cur = hold_d[ptr_q];
         end else if (cur != '0) begin
            cur = cur - 1'b1;
         end
         cnt_d[ptr_q] = cur;
         out_d[ptr_q] = (cur != '0);
         ptr_d        = (ptr_q == PtrMax) ? '0 : ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (aclr) begin
         ptr_q <= '0;
         out_q <= OutRst;
         ack_q <= 1'b0;
         err_q <= 1'b0;
         for (int i = 0; i < int'(CH_NUM); i++) begin
            hold_q[i] <= DefHold;
            cnt_q[i]  <= DefHold;
         end
      end else begin
         ptr_q  <= ptr_d;
         out_q  <= out_d;
         ack_q  <= ack_d;
         err_q  <= err_d;
         hold_q <= hold_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.out     = out_q;
   assign bus.cfg_ack = ack_q;
   assign bus.cfg_err = err_q;
endmodule

// File: tb/tb_cmd_filter_scan.sv
// Bench for cmd_filter_scan: directed corner sequences on a 4-channel instance, a config-write
// vector table plus randomized stimulus against a reference model on a 6-channel instance.
module tb_cmd_filter_scan;
   localparam int unsigned CW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst4;
   logic rst6;

   cmd_filter_scan_if #(.CH_NUM(4), .CNT_WIDTH(CW)) if4 ();
   cmd_filter_scan_if #(.CH_NUM(6), .CNT_WIDTH(CW)) if6 ();

   cmd_filter_scan #(.CH_NUM(4), .CNT_WIDTH(CW), .DEFAULT_HOLD(15)) u_dut4 (
      .clk  (clk),
      .aclr (rst4),
      .bus  (if4)
   );

   cmd_filter_scan #(.CH_NUM(6), .CNT_WIDTH(CW), .DEFAULT_HOLD(15)) u_dut6 (
      .clk  (clk),
      .aclr (rst6),
      .bus  (if6)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit         wr;
      logic [2:0] ch;
      logic [3:0] hold;
      bit         ack;
      bit         err;
      logic [5:0] out;
   } vec_t;

   vec_t tbl [8];

   // Reference model state for the 6-channel instance
   int m_hold [6];
   int m_cnt  [6];
   bit m_out  [6];
   int m_ptr;
   bit m_ack;
   bit m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic m_reset();
      for (int i = 0; i < 6; i++) begin
         m_hold[i] = 15;
         m_cnt[i]  = 15;
         m_out[i]  = 1'b1;
      end
      m_ptr = 0;
      m_ack = 1'b0;
      m_err = 1'b0;
   endtask

   // One clock of the filter: writes first, then the visited channel follows the resulting count.
   task automatic m_step(input logic [5:0] inp, input bit scan, input bit wr, input int ch,
                         input int h);
      int nh [6];
      int nc [6];
      bit no [6];
      nh    = m_hold;
      nc    = m_cnt;
      no    = m_out;
      m_ack = 1'b0;
      m_err = 1'b0;
      if (wr && ch < 6) begin
         nh[ch] = h;
         nc[ch] = (m_cnt[ch] < h) ? m_cnt[ch] : h;
         if (h == 0) no[ch] = 1'b0;
         m_ack = 1'b1;
      end else if (wr) begin
         m_err = 1'b1;
      end
      if (scan) begin
         if (inp[m_ptr]) nc[m_ptr] = nh[m_ptr];
         else if (nc[m_ptr] > 0) nc[m_ptr] = nc[m_ptr] - 1;
         no[m_ptr] = (nc[m_ptr] != 0);
         m_ptr     = (m_ptr + 1) % 6;
      end
      m_hold = nh;
      m_cnt  = nc;
      m_out  = no;
   endtask

   function automatic logic [5:0] m_vec();
      logic [5:0] v;
      for (int i = 0; i < 6; i++) v[i] = m_out[i];
      return v;
   endfunction

   task automatic wr4(input int ch, input int h);
      if4.cfg_wr   = 1'b1;
      if4.cfg_ch   = 2'(ch);
      if4.cfg_hold = 4'(h);
      tick();
      chk($sformatf("wr4_ack_ch%0d", ch), if4.cfg_ack, 1);
      if4.cfg_wr = 1'b0;
   endtask

   initial begin
      logic [5:0] inp;
      bit         r, scan, wr;
      int         ch, h;

      tbl[0] = '{wr: 1, ch: 0, hold: 3, ack: 1, err: 0, out: 6'h3F};
      tbl[1] = '{wr: 1, ch: 6, hold: 0, ack: 0, err: 1, out: 6'h3F};
      tbl[2] = '{wr: 1, ch: 7, hold: 5, ack: 0, err: 1, out: 6'h3F};
      tbl[3] = '{wr: 1, ch: 1, hold: 0, ack: 1, err: 0, out: 6'h3D};
      tbl[4] = '{wr: 1, ch: 5, hold: 0, ack: 1, err: 0, out: 6'h1D};
      tbl[5] = '{wr: 0, ch: 5, hold: 0, ack: 0, err: 0, out: 6'h1D};
      tbl[6] = '{wr: 1, ch: 1, hold: 5, ack: 1, err: 0, out: 6'h1D};
      tbl[7] = '{wr: 1, ch: 6, hold: 0, ack: 0, err: 1, out: 6'h1D};

      rst4 = 1'b1;
      rst6 = 1'b1;
      {if4.in, if4.scan_en, if4.cfg_wr, if4.cfg_ch, if4.cfg_hold} = '0;
      {if6.in, if6.scan_en, if6.cfg_wr, if6.cfg_ch, if6.cfg_hold} = '0;
      tick();
      rst4 = 1'b0;
      rst6 = 1'b0;

      // Reset state, then all channels decay from the default hold of 15 visits
      chk("a_rst_out", if4.out, 4'hF);
      chk("a_rst_ack", if4.cfg_ack, 0);
      chk("a_rst_err", if4.cfg_err, 0);
      if4.scan_en = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (k == 56) chk("a_out_k56", if4.out, 4'hF);
         if (k == 57) chk("a_out_k57", if4.out, 4'hE);
         if (k == 58) chk("a_out_k58", if4.out, 4'hC);
         if (k == 59) chk("a_out_k59", if4.out, 4'h8);
         if (k == 60) chk("a_out_k60", if4.out, 4'h0);
      end

      // Hold timing on channel 2 with hold=3
      if4.scan_en = 1'b0;
      wr4(2, 3);
      if4.scan_en = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         if4.in = (k <= 4) ? 4'b0100 : 4'b0000;
         tick();
         if (k == 1)  chk("b_ack_pulse", if4.cfg_ack, 0);
         if (k == 2)  chk("b_out_k2", if4.out, 4'b0000);
         if (k == 3)  chk("b_out_rise", if4.out, 4'b0100);
         if (k == 14) chk("b_out_k14", if4.out, 4'b0100);
         if (k == 15) chk("b_out_fall", if4.out, 4'b0000);
      end

      // Disable channel 1 while its output is high
      if4.in = 4'b0010;
      repeat (4) tick();
      chk("c_out_up", if4.out, 4'b0010);
      if4.cfg_wr   = 1'b1;
      if4.cfg_ch   = 2'd1;
      if4.cfg_hold = 4'd0;
      tick();
      chk("c_out_dis", if4.out, 4'b0000);
      chk("c_ack", if4.cfg_ack, 1);
      if4.cfg_wr = 1'b0;
      tick();
      chk("c_ack_pulse", if4.cfg_ack, 0);
      repeat (2) tick();
      chk("c_out_held_low", if4.out, 4'b0000);
      if4.in = 4'b0000;

      // Write/service collision on channel 3, then freeze and resume
      if4.scan_en = 1'b0;
      wr4(3, 10);
      if4.scan_en = 1'b1;
      if4.in      = 4'b1000;
      repeat (4) tick();
      chk("e_out_load", if4.out, 4'b1000);
      if4.in = 4'b0000;
      repeat (3) tick();
      if4.cfg_wr   = 1'b1;
      if4.cfg_ch   = 2'd3;
      if4.cfg_hold = 4'd2;
      tick();
      chk("e_coll_out", if4.out, 4'b1000);
      chk("e_coll_ack", if4.cfg_ack, 1);
      if4.cfg_wr  = 1'b0;
      if4.scan_en = 1'b0;
      repeat (21) tick();
      chk("e_frozen", if4.out, 4'b1000);
      if4.scan_en = 1'b1;
      repeat (3) tick();
      chk("e_resume3", if4.out, 4'b1000);
      tick();
      chk("e_fall", if4.out, 4'b0000);

      // Reset asserted during a write to channel 0
      if4.in       = 4'b1111;
      if4.cfg_wr   = 1'b1;
      if4.cfg_ch   = 2'd0;
      if4.cfg_hold = 4'd5;
      rst4         = 1'b1;
      tick();
      rst4        = 1'b0;
      if4.cfg_wr  = 1'b0;
      if4.in      = 4'b0000;
      if4.scan_en = 1'b0;
      chk("f_ack", if4.cfg_ack, 0);
      chk("f_out", if4.out, 4'hF);
      for (int c = 1; c <= 3; c++) wr4(c, 1);
      if4.scan_en = 1'b1;
      for (int k = 1; k <= 61; k++) begin
         if4.in = (k == 1) ? 4'b0001 : 4'b0000;
         tick();
         if (k == 2)  chk("f_order_k2", if4.out, 4'b1101);
         if (k == 4)  chk("f_order_k4", if4.out, 4'b0001);
         if (k == 60) chk("f_hold0_k60", if4.out, 4'b0001);
         if (k == 61) chk("f_hold0_k61", if4.out, 4'b0000);
      end

      // Config-write vectors on the 6-channel instance, scan frozen
      for (int i = 0; i < 8; i++) begin
         if6.cfg_wr   = tbl[i].wr;
         if6.cfg_ch   = tbl[i].ch;
         if6.cfg_hold = tbl[i].hold;
         tick();
         chk($sformatf("t%0d_ack", i), if6.cfg_ack, tbl[i].ack);
         chk($sformatf("t%0d_err", i), if6.cfg_err, tbl[i].err);
         chk($sformatf("t%0d_out", i), if6.out, tbl[i].out);
      end
      if6.cfg_wr = 1'b0;

      // Randomized run against the model
      rst6 = 1'b1;
      tick();
      m_reset();
      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < 6; i++) inp[i] = ($urandom_range(0, 9) == 0);
         scan = ($urandom_range(0, 9) != 0);
         wr   = ($urandom_range(0, 5) == 0);
         ch   = $urandom_range(0, 7);
         h    = $urandom_range(0, 15);
         rst6         = r;
         if6.in       = inp;
         if6.scan_en  = scan;
         if6.cfg_wr   = wr;
         if6.cfg_ch   = 3'(ch);
         if6.cfg_hold = 4'(h);
         if (r) m_reset();
         else m_step(inp, scan, wr, ch, h);
         tick();
         chk($sformatf("r%0d_out", n), if6.out, m_vec());
         chk($sformatf("r%0d_ack", n), if6.cfg_ack, m_ack);
         chk($sformatf("r%0d_err", n), if6.cfg_err, m_err);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
